// File: rtl/psk_pkg.sv
// Shared helpers for the PSK receiver datapath: lane slicing, log sizing and
// two's-complement magnitude limits.
package psk_pkg;

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    function automatic int unsigned ceil_log2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

    // MAG_MAX_SAT = 2^(w-1)-1, MOST_NEG = 2^(w-1)
    function automatic int unsigned mag_max_sat(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    function automatic int unsigned most_neg(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/abs_lane.sv
// Single-lane registered absolute value with clock enable and valid; the
// output holds its last magnitude while no beat is accepted.
module abs_lane
    import psk_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_enable,
    input  logic             vld,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] abs_out,
    output logic             abs_vld
);

    localparam logic [WIDTH-1:0] MAG_MAX_SAT = WIDTH'(mag_max_sat(WIDTH));
    localparam logic [WIDTH-1:0] MOST_NEG    = WIDTH'(most_neg(WIDTH));

    logic [WIDTH-1:0] mag_d;
    logic [WIDTH-1:0] abs_q;
    logic             vld_q;

    always_comb begin
        mag_d = in;
        if (in[WIDTH-1]) begin
            mag_d = ~in + 1'b1;
            // Negating the most-negative value wraps to itself, which is the exact
            // unsigned magnitude; only the saturating variant needs to clamp.
            if (SATURATE && (in == MOST_NEG)) begin
                mag_d = MAG_MAX_SAT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            abs_q <= '0;
            vld_q <= 1'b0;
        end else if (clk_enable) begin
            vld_q <= vld;
            if (vld) begin
                abs_q <= mag_d;
            end
        end
    end

    assign abs_out = abs_q;
    assign abs_vld = vld_q;

endmodule

// File: rtl/abs_window_stats.sv
// Multi-lane magnitude stage with per-lane windowed sum, mean and peak over
// 2^WIN_LOG2 accepted beats.
module abs_window_stats
    import psk_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned WIN_LOG2 = 8,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clk_enable,
    input  logic                               vld,
    input  logic                               clear,
    input  logic [CHANNELS*WIDTH-1:0]          in,
    output logic [CHANNELS*WIDTH-1:0]          abs_out,
    output logic                               abs_vld,
    output logic [CHANNELS*(WIDTH+WIN_LOG2)-1:0] sum_out,
    output logic [CHANNELS*WIDTH-1:0]          mean_out,
    output logic [CHANNELS*WIDTH-1:0]          peak_out,
    output logic                               win_done,
    output logic [WIN_LOG2-1:0]                win_cnt
);

    localparam int unsigned SW = WIDTH + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] LAST_BEAT = '1;

    logic [CHANNELS-1:0] lane_vld;
    logic [SW-1:0]       acc_q    [CHANNELS];
    logic [WIDTH-1:0]    peak_q   [CHANNELS];
    logic [SW-1:0]       sum_nxt  [CHANNELS];
    logic [WIDTH-1:0]    peak_nxt [CHANNELS];

    logic [CHANNELS*SW-1:0]    sum_q;
    logic [CHANNELS*WIDTH-1:0] mean_q;
    logic [CHANNELS*WIDTH-1:0] pk_q;
    logic                      done_q;
    logic [WIN_LOG2-1:0]       cnt_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        localparam int unsigned LSB = lane_lsb(k, WIDTH);

        abs_lane #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_abs_lane (
            .clk        (clk),
            .rst        (rst),
            .clk_enable (clk_enable),
            .vld        (vld),
            .in         (in[LSB +: WIDTH]),
            .abs_out    (abs_out[LSB +: WIDTH]),
            .abs_vld    (lane_vld[k])
        );

        assign sum_nxt[k]  = acc_q[k] + {{WIN_LOG2{1'b0}}, abs_out[LSB +: WIDTH]};
        assign peak_nxt[k] = (abs_out[LSB +: WIDTH] > peak_q[k]) ? abs_out[LSB +: WIDTH]
                                                                  : peak_q[k];
    end

    // All lanes share one valid pipeline, so the AND is just a fan-in of equals.
    assign abs_vld = &lane_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            sum_q  <= '0;
            mean_q <= '0;
            pk_q   <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                acc_q[k]  <= '0;
                peak_q[k] <= '0;
            end
        end else if (clk_enable) begin
            done_q <= 1'b0;
            if (clear) begin
                cnt_q <= '0;
                for (int k = 0; k < CHANNELS; k++) begin
                    acc_q[k]  <= '0;
                    peak_q[k] <= '0;
                end
            end else if (abs_vld) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == LAST_BEAT) begin
                    done_q <= 1'b1;
                    for (int k = 0; k < CHANNELS; k++) begin
                        sum_q[k*SW +: SW]     <= sum_nxt[k];
                        mean_q[k*WIDTH +: WIDTH] <= sum_nxt[k][WIN_LOG2 +: WIDTH];
                        pk_q[k*WIDTH +: WIDTH]   <= peak_nxt[k];
                        acc_q[k]  <= '0;
                        peak_q[k] <= '0;
                    end
                end else begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        acc_q[k]  <= sum_nxt[k];
                        peak_q[k] <= peak_nxt[k];
                    end
                end
            end
        end
    end

    assign sum_out  = sum_q;
    assign mean_out = mean_q;
    assign peak_out = pk_q;
    assign win_done = done_q;
    assign win_cnt  = cnt_q;

endmodule

// File: tb/tb_abs_window_stats.sv
// Directed bench for abs_window_stats with WIDTH=16, CHANNELS=2, WIN_LOG2=2;
// a second instance with SATURATE=0 shares the stimulus.
module tb_abs_window_stats;

    localparam int unsigned W  = 16;
    localparam int unsigned CH = 2;
    localparam int unsigned WL = 2;
    localparam int unsigned SW = W + WL;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_enable;
    logic              vld;
    logic              clear;
    logic [CH*W-1:0]   in;
    logic [CH*W-1:0]   abs_out,  abs_out_ns;
    logic              abs_vld,  abs_vld_ns;
    logic [CH*SW-1:0]  sum_out,  sum_out_ns;
    logic [CH*W-1:0]   mean_out, mean_out_ns;
    logic [CH*W-1:0]   peak_out, peak_out_ns;
    logic              win_done, win_done_ns;
    logic [WL-1:0]     win_cnt,  win_cnt_ns;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    abs_window_stats #(.WIDTH(W), .CHANNELS(CH), .WIN_LOG2(WL), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .vld(vld), .clear(clear), .in(in),
        .abs_out(abs_out), .abs_vld(abs_vld), .sum_out(sum_out), .mean_out(mean_out),
        .peak_out(peak_out), .win_done(win_done), .win_cnt(win_cnt)
    );

    abs_window_stats #(.WIDTH(W), .CHANNELS(CH), .WIN_LOG2(WL), .SATURATE(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .vld(vld), .clear(clear), .in(in),
        .abs_out(abs_out_ns), .abs_vld(abs_vld_ns), .sum_out(sum_out_ns),
        .mean_out(mean_out_ns), .peak_out(peak_out_ns), .win_done(win_done_ns),
        .win_cnt(win_cnt_ns)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [W-1:0] l0, input logic [W-1:0] l1);
        in  = {l1, l0};
        vld = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; vld = 1'b0; clear = 1'b0; clk_enable = 1'b1; in = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; vld = 1'b1; clear = 1'b0; clk_enable = 1'b1; in = 32'h1234_8765;
        tick(); tick();
        total++; if (abs_out !== '0) begin bad++; $display("FAIL reset_abs got=%h exp=0", abs_out); end
        total++; if (abs_vld !== 1'b0) begin bad++; $display("FAIL reset_abs_vld got=%b exp=0", abs_vld); end
        total++; if (sum_out !== '0 || mean_out !== '0 || peak_out !== '0) begin
            bad++; $display("FAIL reset_stats got=%h/%h/%h exp=0", sum_out, mean_out, peak_out); end
        total++; if (win_done !== 1'b0 || win_cnt !== '0) begin
            bad++; $display("FAIL reset_win got=%b/%0d exp=0/0", win_done, win_cnt); end
        rst = 1'b0; vld = 1'b0;
    endtask

    task automatic test_single_beat();
        do_reset();
        feed(16'hFFFB, 16'd7);
        vld = 1'b0;
        total++; if (abs_out !== {16'd7, 16'd5}) begin bad++; $display("FAIL single_abs got=%h exp=%h", abs_out, {16'd7, 16'd5}); end
        total++; if (abs_vld !== 1'b1) begin bad++; $display("FAIL single_vld got=%b exp=1", abs_vld); end
        tick();
        total++; if (abs_vld !== 1'b0) begin bad++; $display("FAIL single_vld_drop got=%b exp=0", abs_vld); end
        total++; if (abs_out !== {16'd7, 16'd5}) begin bad++; $display("FAIL single_hold got=%h exp=%h", abs_out, {16'd7, 16'd5}); end
    endtask

    task automatic test_most_neg();
        do_reset();
        feed(16'h8000, 16'h0001);
        vld = 1'b0;
        total++; if (abs_out !== {16'h0001, 16'h7FFF}) begin bad++; $display("FAIL mostneg_sat got=%h exp=%h", abs_out, {16'h0001, 16'h7FFF}); end
        total++; if (abs_out_ns !== {16'h0001, 16'h8000}) begin bad++; $display("FAIL mostneg_exact got=%h exp=%h", abs_out_ns, {16'h0001, 16'h8000}); end
    endtask

    task automatic test_full_window();
        do_reset();
        feed(-16'sd3, -16'sd100);
        feed(16'd10, -16'sd100);
        feed(-16'sd1, -16'sd100);
        feed(16'd4, -16'sd100);
        vld = 1'b0;
        total++; if (win_done !== 1'b0) begin bad++; $display("FAIL win_early got=%b exp=0", win_done); end
        tick();
        total++; if (win_done !== 1'b1) begin bad++; $display("FAIL win_done got=%b exp=1", win_done); end
        total++; if (sum_out !== {18'd400, 18'd18}) begin bad++; $display("FAIL win_sum got=%h exp=%h", sum_out, {18'd400, 18'd18}); end
        total++; if (mean_out !== {16'd100, 16'd4}) begin bad++; $display("FAIL win_mean got=%h exp=%h", mean_out, {16'd100, 16'd4}); end
        total++; if (peak_out !== {16'd100, 16'd10}) begin bad++; $display("FAIL win_peak got=%h exp=%h", peak_out, {16'd100, 16'd10}); end
        total++; if (win_cnt !== 2'd0) begin bad++; $display("FAIL win_cnt got=%0d exp=0", win_cnt); end
        tick();
        total++; if (win_done !== 1'b0) begin bad++; $display("FAIL win_pulse got=%b exp=0", win_done); end
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        int pulses;
        first = -1; second = -1; pulses = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i < 4) begin
                in = {16'd0, 16'(i + 1)}; vld = 1'b1;
            end else if (i < 8) begin
                in = {16'hFFFF, 16'h8000}; vld = 1'b1;
            end else begin
                vld = 1'b0;
            end
            tick();
            if (win_done === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    total++; if (sum_out !== {18'd0, 18'd10} || peak_out !== {16'd0, 16'd4}) begin
                        bad++; $display("FAIL b2b_w1 got=%h/%h exp=%h/%h", sum_out, peak_out, {18'd0, 18'd10}, {16'd0, 16'd4}); end
                end else begin
                    second = i;
                    total++; if (sum_out !== {18'd4, 18'h1FFFC}) begin bad++; $display("FAIL b2b_sum got=%h exp=%h", sum_out, {18'd4, 18'h1FFFC}); end
                    total++; if (mean_out !== {16'd1, 16'h7FFF} || peak_out !== {16'd1, 16'h7FFF}) begin
                        bad++; $display("FAIL b2b_mean_peak got=%h/%h exp=%h/%h", mean_out, peak_out, {16'd1, 16'h7FFF}, {16'd1, 16'h7FFF}); end
                    total++; if (sum_out_ns !== {18'd4, 18'h20000} || mean_out_ns !== {16'd1, 16'h8000}) begin
                        bad++; $display("FAIL b2b_exact got=%h/%h exp=%h/%h", sum_out_ns, mean_out_ns, {18'd4, 18'h20000}, {16'd1, 16'h8000}); end
                end
            end
        end
        total++; if (pulses != 2 || second - first != 4) begin
            bad++; $display("FAIL b2b_spacing got=%0d pulses gap %0d exp=2 pulses gap 4", pulses, second - first); end
    endtask

    task automatic test_enable_stall();
        do_reset();
        feed(16'd1, 16'd2);
        feed(16'd2, 16'd2);
        clk_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            feed(16'd100, 16'd100);
        end
        total++; if (abs_out !== {16'd2, 16'd2} || abs_vld !== 1'b1) begin
            bad++; $display("FAIL stall_abs got=%h/%b exp=%h/1", abs_out, abs_vld, {16'd2, 16'd2}); end
        total++; if (win_cnt !== 2'd1) begin bad++; $display("FAIL stall_cnt got=%0d exp=1", win_cnt); end
        clk_enable = 1'b1;
        feed(16'd3, 16'd2);
        feed(16'd4, 16'd2);
        vld = 1'b0;
        total++; if (win_done !== 1'b0) begin bad++; $display("FAIL stall_early got=%b exp=0", win_done); end
        tick();
        total++; if (win_done !== 1'b1 || sum_out !== {18'd8, 18'd10}) begin
            bad++; $display("FAIL stall_win got=%b/%h exp=1/%h", win_done, sum_out, {18'd8, 18'd10}); end
        total++; if (mean_out !== {16'd2, 16'd2} || peak_out !== {16'd2, 16'd4}) begin
            bad++; $display("FAIL stall_stats got=%h/%h exp=%h/%h", mean_out, peak_out, {16'd2, 16'd2}, {16'd2, 16'd4}); end
        clk_enable = 1'b0;
        tick();
        total++; if (win_done !== 1'b1) begin bad++; $display("FAIL stall_stretch got=%b exp=1", win_done); end
        clk_enable = 1'b1;
        tick();
    endtask

    task automatic test_clear_and_rst();
        int spurious;
        spurious = 0;
        feed(16'd50, 16'd50);
        feed(16'd60, 16'd60);
        feed(16'd70, 16'd70);
        if (win_done === 1'b1) spurious++;
        vld = 1'b0; clear = 1'b1;
        tick();
        if (win_done === 1'b1) spurious++;
        clear = 1'b0;
        total++; if (win_cnt !== 2'd0 || sum_out !== {18'd8, 18'd10}) begin
            bad++; $display("FAIL clear_hold got=%0d/%h exp=0/%h", win_cnt, sum_out, {18'd8, 18'd10}); end
        total++; if (abs_out !== {16'd70, 16'd70}) begin bad++; $display("FAIL clear_stage1 got=%h exp=%h", abs_out, {16'd70, 16'd70}); end
        feed(16'd5, -16'sd2);
        if (win_done === 1'b1) spurious++;
        feed(16'd6, -16'sd2);
        if (win_done === 1'b1) spurious++;
        feed(16'd7, -16'sd2);
        if (win_done === 1'b1) spurious++;
        feed(16'd8, -16'sd2);
        if (win_done === 1'b1) spurious++;
        vld = 1'b0;
        total++; if (spurious != 0) begin bad++; $display("FAIL clear_no_done got=%0d exp=0", spurious); end
        tick();
        total++; if (win_done !== 1'b1 || sum_out !== {18'd8, 18'd26}) begin
            bad++; $display("FAIL clear_win got=%b/%h exp=1/%h", win_done, sum_out, {18'd8, 18'd26}); end
        total++; if (mean_out !== {16'd2, 16'd6} || peak_out !== {16'd2, 16'd8}) begin
            bad++; $display("FAIL clear_stats got=%h/%h exp=%h/%h", mean_out, peak_out, {16'd2, 16'd6}, {16'd2, 16'd8}); end
        feed(16'd9, 16'd9);
        feed(16'd9, 16'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0; vld = 1'b0;
        total++; if (abs_out !== '0 || abs_vld !== 1'b0 || win_cnt !== '0 || win_done !== 1'b0) begin
            bad++; $display("FAIL rst_mid got=%h/%b/%0d/%b exp=0", abs_out, abs_vld, win_cnt, win_done); end
        total++; if (sum_out !== '0 || mean_out !== '0 || peak_out !== '0) begin
            bad++; $display("FAIL rst_stats got=%h/%h/%h exp=0", sum_out, mean_out, peak_out); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (win_done !== 1'b0) begin bad++; $display("FAIL rst_no_done got=%b exp=0", win_done); end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_most_neg();
        test_full_window();
        test_back_to_back();
        test_enable_stall();
        test_clear_and_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
